// File: rtl/alu.sv
// Registered 32-bit ALU: combinational op select on A/B/Opin, one output register.
// Define ALU_FLAGS_EN to add registered zero/negative/carry/overflow outputs.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Opin,
`ifdef ALU_FLAGS_EN
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
`endif
  output logic [WIDTH-1:0] result
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_NOR   = 4'b0101,
    OP_SLL   = 4'b0110,
    OP_SRL   = 4'b0111,
    OP_SRA   = 4'b1000,
    OP_SLT   = 4'b1001,
    OP_SLTU  = 4'b1010,
    OP_PASSB = 4'b1011,
    OP_PASSA = 4'b1100,
    OP_NOT   = 4'b1101,
    OP_INC   = 4'b1110,
    OP_DEC   = 4'b1111
  } op_e;

  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;
  logic [4:0]       shamt;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;
  logic [WIDTH-1:0] one;

  assign one   = {{(WIDTH-1){1'b0}}, 1'b1};
  assign shamt = B[4:0];

  // One extra bit on each adder: the carry-out / borrow feeds the flags build.
  assign add_ext = {1'b0, A} + {1'b0, B};
  assign sub_ext = {1'b0, A} - {1'b0, B};
  assign inc_ext = {1'b0, A} + {1'b0, one};
  assign dec_ext = {1'b0, A} - {1'b0, one};

  always_comb begin
    result_d = '0;
    case (op_e'(Opin))
      OP_ADD:   result_d = add_ext[WIDTH-1:0];
      OP_SUB:   result_d = sub_ext[WIDTH-1:0];
      OP_AND:   result_d = A & B;
      OP_OR:    result_d = A | B;
      OP_XOR:   result_d = A ^ B;
      OP_NOR:   result_d = ~(A | B);
      OP_SLL:   result_d = A << shamt;
      OP_SRL:   result_d = A >> shamt;
      OP_SRA:   result_d = $unsigned($signed(A) >>> shamt);
      OP_SLT:   result_d = ($signed(A) < $signed(B)) ? one : '0;
      OP_SLTU:  result_d = (A < B) ? one : '0;
      OP_PASSB: result_d = B;
      OP_PASSA: result_d = A;
      OP_NOT:   result_d = ~A;
      OP_INC:   result_d = inc_ext[WIDTH-1:0];
      OP_DEC:   result_d = dec_ext[WIDTH-1:0];
      default:  result_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) result_q <= '0;
    else        result_q <= result_d;
  end

  assign result = result_q;

`ifdef ALU_FLAGS_EN
  logic zero_d, negative_d, carry_d, overflow_d;
  logic zero_q, negative_q, carry_q, overflow_q;

  always_comb begin
    zero_d     = (result_d == '0);
    negative_d = result_d[WIDTH-1];
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    case (op_e'(Opin))
      OP_ADD: begin
        carry_d    = add_ext[WIDTH];
        overflow_d = (A[WIDTH-1] == B[WIDTH-1]) && (result_d[WIDTH-1] != A[WIDTH-1]);
      end
      // Subtract-style carry is "no borrow", as in ARM-like flag conventions.
      OP_SUB: begin
        carry_d    = ~sub_ext[WIDTH];
        overflow_d = (A[WIDTH-1] != B[WIDTH-1]) && (result_d[WIDTH-1] != A[WIDTH-1]);
      end
      OP_INC: begin
        carry_d    = inc_ext[WIDTH];
        overflow_d = ~A[WIDTH-1] & result_d[WIDTH-1];
      end
      OP_DEC: begin
        carry_d    = ~dec_ext[WIDTH];
        overflow_d = A[WIDTH-1] & ~result_d[WIDTH-1];
      end
      default: begin
        carry_d    = 1'b0;
        overflow_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      zero_q     <= zero_d;
      negative_q <= negative_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

  assign zero     = zero_q;
  assign negative = negative_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: hand-computed vectors, async reset checks, optional flags.
module tb_alu;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  Opin;
  logic [31:0] result;
`ifdef ALU_FLAGS_EN
  logic        zero, negative, carry, overflow;
`endif

  int tests_run;
  int tests_failed;

  alu dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .Opin     (Opin),
`ifdef ALU_FLAGS_EN
    .zero     (zero),
    .negative (negative),
    .carry    (carry),
    .overflow (overflow),
`endif
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
      $error("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive operands, let one rising edge capture them, then check 1 ns later.
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic [31:0] exp);
    A    = a;
    B    = b;
    Opin = op;
    @(posedge clk);
    #1;
    check(tag, result, exp);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b0;
    A     = 32'd27;
    B     = 32'd46;
    Opin  = 4'b0000;

    #3;
    check("reset_t0", result, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", result, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_release_no_edge", result, 32'h0);
    @(posedge clk);
    #1;
    check("first_add", result, 32'h00000049);

    step("xor",  32'h1B, 32'h2E, 4'b0100, 32'h00000035);
    step("and",  32'h1B, 32'h2E, 4'b0010, 32'h0000000A);
    step("or",   32'h1B, 32'h2E, 4'b0011, 32'h0000003F);
    step("nor",  32'h1B, 32'h2E, 4'b0101, 32'hFFFFFFC0);
    step("sub",  32'd27, 32'd46, 4'b0001, 32'hFFFFFFED);
    step("add_wrap", 32'hFFFFFFFF, 32'd1, 4'b0000, 32'h00000000);
    step("dec_wrap", 32'h0, 32'h0, 4'b1111, 32'hFFFFFFFF);
    step("inc_wrap", 32'hFFFFFFFF, 32'h0, 4'b1110, 32'h00000000);
    step("slt",  32'hFFFFFFFF, 32'd1, 4'b1001, 32'h00000001);
    step("sltu", 32'hFFFFFFFF, 32'd1, 4'b1010, 32'h00000000);
    step("slt_false", 32'd5, 32'hFFFFFFFE, 4'b1001, 32'h00000000);
    step("sltu_true", 32'd5, 32'hFFFFFFFE, 4'b1010, 32'h00000001);
    step("sll14", 32'd27, 32'd46, 4'b0110, 32'h0006C000);
    step("sra4", 32'h80000000, 32'd4, 4'b1000, 32'hF8000000);
    step("srl4", 32'h80000000, 32'd4, 4'b0111, 32'h08000000);
    step("sra_hi_bits_ignored", 32'h80000000, 32'hFFFFFFE4, 4'b1000, 32'hF8000000);
    step("sll_by0", 32'h1234ABCD, 32'h00000020, 4'b0110, 32'h1234ABCD);
    step("srl31", 32'h80000000, 32'd31, 4'b0111, 32'h00000001);
    step("passb", 32'h1B, 32'hDEADBEEF, 4'b1011, 32'hDEADBEEF);
    step("passa", 32'hCAFEF00D, 32'h2E, 4'b1100, 32'hCAFEF00D);
    step("not",  32'h1B, 32'h2E, 4'b1101, 32'hFFFFFFE4);
    step("sub_eq", 32'h55, 32'h55, 4'b0001, 32'h00000000);

    // Opcode changes every edge, then reset drops between edges.
    step("toggle_add", 32'd27, 32'd46, 4'b0000, 32'h00000049);
    step("toggle_or",  32'd27, 32'd46, 4'b0011, 32'h0000003F);
    step("toggle_xor", 32'd27, 32'd46, 4'b0100, 32'h00000035);
    Opin = 4'b0000;
    #1;
    reset = 1'b0;
    #1;
    check("async_reset_between_edges", result, 32'h0);
    @(posedge clk);
    #1;
    check("async_reset_hold1", result, 32'h0);
    Opin = 4'b0011;
    @(posedge clk);
    #1;
    check("async_reset_hold2", result, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_release_no_edge", result, 32'h0);
    @(posedge clk);
    #1;
    check("after_async_release", result, 32'h0000003F);

`ifdef ALU_FLAGS_EN
    step("flags_ovf_res", 32'h7FFFFFFF, 32'd1, 4'b0000, 32'h80000000);
    check("flags_ovf_overflow", {31'b0, overflow}, 32'd1);
    check("flags_ovf_negative", {31'b0, negative}, 32'd1);
    check("flags_ovf_carry",    {31'b0, carry},    32'd0);
    check("flags_ovf_zero",     {31'b0, zero},     32'd0);
    step("flags_wrap_res", 32'hFFFFFFFF, 32'd1, 4'b0000, 32'h00000000);
    check("flags_wrap_zero",     {31'b0, zero},     32'd1);
    check("flags_wrap_carry",    {31'b0, carry},    32'd1);
    check("flags_wrap_overflow", {31'b0, overflow}, 32'd0);
    check("flags_wrap_negative", {31'b0, negative}, 32'd0);
    step("flags_sub_borrow_res", 32'd27, 32'd46, 4'b0001, 32'hFFFFFFED);
    check("flags_sub_borrow_carry", {31'b0, carry}, 32'd0);
    step("flags_sub_ok_res", 32'd46, 32'd27, 4'b0001, 32'h00000013);
    check("flags_sub_ok_carry", {31'b0, carry}, 32'd1);
    step("flags_dec_ovf_res", 32'h80000000, 32'd0, 4'b1111, 32'h7FFFFFFF);
    check("flags_dec_ovf_overflow", {31'b0, overflow}, 32'd1);
    check("flags_dec_ovf_carry",    {31'b0, carry},    32'd1);
    step("flags_logic_res", 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0010, 32'hFFFFFFFF);
    check("flags_logic_carry", {31'b0, carry}, 32'd0);
    check("flags_logic_neg",   {31'b0, negative}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
